// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared state type, requester count and the round-robin pick used by mux4_rr_arbiter.
package mux4_arb_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  localparam int N_REQ = 4;
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr, input logic [3:0] exclude);
    logic [3:0] m;
    logic [1:0] i;
    logic [2:0] r;
    m = req & ~exclude;
    r = 3'b000;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      i = ptr + 2'(k);
      if (m[i]) r = {1'b1, i};
    end
    return r;
  endfunction
endpackage

// File: rtl/mux4.sv
// mux4: single-bit 4:1 mux with inverted select polarity (sel 00 routes a[3], 11 routes a[0]).
module mux4 (
  input  logic [3:0] a,
  input  logic [1:0] sel,
  output logic       y
);
  logic [1:0] idx;
  assign idx = ~sel;
  assign y = a[idx];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner of a shared mux4 path; grants held while requested.
// Optional hold timeout enabled by defining MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic [1:0] select_line,
  output logic       data_out,
  output logic       valid
);
  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic       valid_q, valid_d;
  logic [2:0] pick;
  logic       timeout, hold, mux_y;
`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q >= CNT_W'(MAX_HOLD);
`else
  localparam int unused_cfg = MAX_HOLD + CNT_W;
  assign timeout = 1'b0;
`endif
  assign hold = req[owner_q] & ~timeout;
  // While granted, the search starts after the owner and skips it so others win first.
  assign pick = rr_pick(req, state_q == GRANT ? owner_q + 2'd1 : ptr_q,
                        state_q == GRANT ? grant_q : 4'b0000);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      state_d = pick[2] ? GRANT : IDLE;
      owner_d = pick[2] ? pick[1:0] : 2'd0;
    end else if (!hold) begin
      ptr_d   = owner_q + 2'd1;
      state_d = (pick[2] || req[owner_q]) ? GRANT : IDLE;
      owner_d = pick[2] ? pick[1:0] : req[owner_q] ? owner_q : 2'd0;
    end
    grant_d = state_d == GRANT ? 4'b0001 << owner_d : 4'b0000;
    valid_d = state_d == GRANT;
  end
`ifdef MUX4_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = state_d == IDLE ? '0 :
            (state_q == IDLE || !hold) ? CNT_W'(1) :
            &cnt_q ? cnt_q : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
    end
  end
  mux4 u_mux (.a(data_in), .sel(select_line), .y(mux_y));
  assign grant       = grant_q;
  assign owner       = owner_q;
  assign valid       = valid_q;
  assign select_line = ~owner_q;
  assign data_out    = valid_q & mux_y;
endmodule
